// File: rtl/onewire_master.sv
// onewire_master
//   Single-wire bus master. It drives the D/E/Y side of a bidirectional pad
//   in open-drain fashion: D is tied low, and E pulls the line low when high.
//   It runs bus reset/presence, write-byte and read-byte transactions behind
//   a valid/ready command interface. All slot timing is counted in clock cycles.
//
// Ports
//   CLK, RESET        clock; asynchronous active-high reset
//   CMD_VALID/READY   command handshake (accepted when both are high)
//   CMD_OP            00 bus reset, 01 write byte, 10 read byte, 11 no-op
//   CMD_DATA          byte to write, sent LSB first
//   RSP_VALID         one-cycle completion pulse
//   RSP_DATA          read byte (bit i = slot i), 0 for other ops
//   RSP_PRESENCE      slave presence seen during a bus reset
//   BUSY              transaction in progress
//   IO_D, IO_E, IO_Y  pad data (always 0), pad enable (1 = pull low), line level
//
// State      | meaning
// S_IDLE     | ready for a command
// S_RST_LOW  | bus held low for the reset pulse
// S_RST_HIGH | bus released, presence sampled
// S_SLOT     | one bit slot (low phase, then released)
// S_RECOVER  | released recovery gap after a slot
// S_DONE     | issue the response pulse

module onewire_master #(
    parameter int T_RSTL = 24000,
    parameter int T_RSTH = 24000,
    parameter int T_PDS  = 3500,
    parameter int T_SLOT = 3500,
    parameter int T_LOW0 = 3000,
    parameter int T_LOW1 = 300,
    parameter int T_RDS  = 750,
    parameter int T_REC  = 500
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic [1:0] CMD_OP,
    input  logic [7:0] CMD_DATA,
    output logic       RSP_VALID,
    output logic [7:0] RSP_DATA,
    output logic       RSP_PRESENCE,
    output logic       BUSY,
    output logic       IO_D,
    output logic       IO_E,
    input  logic       IO_Y
);

    localparam int MAX_A  = (T_RSTL > T_RSTH) ? T_RSTL : T_RSTH;
    localparam int MAX_B  = (T_SLOT > T_REC)  ? T_SLOT : T_REC;
    localparam int MAX_T  = (MAX_A > MAX_B)   ? MAX_A  : MAX_B;
    localparam int CW     = $clog2(MAX_T) + 1;

    localparam logic [1:0] OP_RESET = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_RST_LOW, S_RST_HIGH, S_SLOT, S_RECOVER, S_DONE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_idx;
    logic [1:0]      r_op;
    logic [7:0]      r_data;
    logic [7:0]      r_shift;
    logic            r_pres;
    logic            r_y_meta;
    logic            r_y_sync;
    logic            r_io_e;
    logic            r_cmd_ready;
    logic            r_busy;
    logic            r_rsp_valid;
    logic [7:0]      r_rsp_data;
    logic            r_rsp_pres;
    logic [CW-1:0]   w_low_cur;
    logic [CW-1:0]   w_low_next;

    // Write-0 bits hold the line low long; read and write-1 bits only pulse it.
    function automatic logic [CW-1:0] f_low(input logic [1:0] op, input logic b);
        return (op == OP_WRITE && !b) ? CW'(T_LOW0) : CW'(T_LOW1);
    endfunction

    assign w_low_cur  = f_low(r_op, r_data[r_idx]);
    assign w_low_next = f_low(r_op, r_data[r_idx + 3'd1]);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_op        <= '0;
            r_data      <= '0;
            r_shift     <= '0;
            r_pres      <= 1'b0;
            r_y_meta    <= 1'b1;
            r_y_sync    <= 1'b1;
            r_io_e      <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_pres  <= 1'b0;
        end else begin
            r_y_meta <= IO_Y;
            r_y_sync <= r_y_meta;
            case (r_state)
                S_IDLE: begin
                    r_rsp_valid <= 1'b0;
                    if (CMD_VALID && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_op        <= CMD_OP;
                        r_data      <= CMD_DATA;
                        r_idx       <= '0;
                        r_cnt       <= '0;
                        r_shift     <= '0;
                        r_pres      <= 1'b0;
                        // IO_E is registered, so the low phase is launched
                        // together with the state change to keep widths exact.
                        case (CMD_OP)
                            OP_RESET: begin
                                r_state <= S_RST_LOW;
                                r_io_e  <= 1'b1;
                            end
                            OP_WRITE, OP_READ: begin
                                r_state <= S_SLOT;
                                r_io_e  <= (f_low(CMD_OP, CMD_DATA[0]) != '0);
                            end
                            default: r_state <= S_DONE;
                        endcase
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                S_RST_LOW: begin
                    if (r_cnt == CW'(T_RSTL - 1)) begin
                        r_state <= S_RST_HIGH;
                        r_cnt   <= '0;
                        r_io_e  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RST_HIGH: begin
                    if (r_cnt == CW'(T_PDS))
                        r_pres <= ~r_y_sync;
                    if (r_cnt == CW'(T_RSTH - 1)) begin
                        r_state <= S_DONE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_SLOT: begin
                    if (r_op == OP_READ && r_cnt == CW'(T_RDS))
                        r_shift[r_idx] <= r_y_sync;
                    if (r_cnt == CW'(T_SLOT - 1)) begin
                        r_state <= S_RECOVER;
                        r_cnt   <= '0;
                        r_io_e  <= 1'b0;
                    end else begin
                        r_cnt  <= r_cnt + CW'(1);
                        r_io_e <= ((r_cnt + CW'(1)) < w_low_cur);
                    end
                end
                S_RECOVER: begin
                    if (r_cnt == CW'(T_REC - 1)) begin
                        r_cnt <= '0;
                        if (r_idx == 3'd7) begin
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_state <= S_SLOT;
                            r_io_e  <= (w_low_next != '0);
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= (r_op == OP_READ)  ? r_shift : 8'h00;
                    r_rsp_pres  <= (r_op == OP_RESET) ? r_pres  : 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign CMD_READY    = r_cmd_ready;
    assign BUSY         = r_busy;
    assign RSP_VALID    = r_rsp_valid;
    assign RSP_DATA     = r_rsp_data;
    assign RSP_PRESENCE = r_rsp_pres;
    assign IO_E         = r_io_e;
    assign IO_D         = 1'b0;

endmodule

// File: tb/tb_onewire_master.sv
module tb_onewire_master;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       CMD_VALID = 1'b0;
    logic [1:0] CMD_OP = 2'b00;
    logic [7:0] CMD_DATA = 8'h00;
    logic       CMD_READY, RSP_VALID, RSP_PRESENCE, BUSY, IO_D, IO_E, IO_Y;
    logic [7:0] RSP_DATA;
    logic       pull = 1'b0;

    assign IO_Y = ~(IO_E | pull);

    onewire_master #(
        .T_RSTL(48), .T_RSTH(48), .T_PDS(7), .T_SLOT(20),
        .T_LOW0(16), .T_LOW1(2), .T_RDS(5), .T_REC(4)
    ) dut (
        .CLK(CLK), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_OP(CMD_OP), .CMD_DATA(CMD_DATA), .RSP_VALID(RSP_VALID),
        .RSP_DATA(RSP_DATA), .RSP_PRESENCE(RSP_PRESENCE), .BUSY(BUSY),
        .IO_D(IO_D), .IO_E(IO_E), .IO_Y(IO_Y)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] data;
        logic       pres;
        int         lat;
    } rsp_t;

    rsp_t exp_q[$];
    int   acc_q[$];
    int   wid_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   wcnt = 0;

    // slave model controls: 0 = silent, 1 = presence pulse, 2 = read responder
    int         slave_mode = 0;
    logic [7:0] rd_mask = 8'h00;
    logic       prev_e = 1'b0;
    int         pcnt = -1;
    int         hold = 0;
    int         rd_idx = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_rsp(input logic [7:0] d, input logic p, input int lat);
        rsp_t e;
        e.data = d;
        e.pres = p;
        e.lat  = lat;
        exp_q.push_back(e);
    endtask

    task automatic push_widths(input logic [1:0] op, input logic [7:0] d);
        for (int i = 0; i < 8; i++)
            wid_q.push_back((op == 2'b01 && !d[i]) ? 16 : 2);
    endtask

    // scoreboard monitor: responses and IO_E pulse widths
    always @(negedge CLK) begin
        rsp_t e;
        int   a;
        if (RESET) begin
            acc_q.delete();
            wcnt = 0;
        end else begin
            if (CMD_VALID && CMD_READY) acc_q.push_back(cyc);
            if (RSP_VALID) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    a = (acc_q.size() != 0) ? acc_q.pop_front() : -100000;
                    chk("rsp_latency", cyc - a, e.lat);
                    chk("rsp_data", int'(RSP_DATA), int'(e.data));
                    chk("rsp_presence", int'(RSP_PRESENCE), int'(e.pres));
                end
            end
            if (IO_E) begin
                wcnt++;
            end else if (wcnt > 0) begin
                if (wid_q.size() == 0) chk("unexpected_io_e_pulse", wcnt, 0);
                else chk("io_e_width", wcnt, wid_q.pop_front());
                wcnt = 0;
            end
            chk("io_d_zero", int'(IO_D), 0);
        end
    end

    // slave device model, updates the line away from the active edge
    always @(negedge CLK) begin
        if (slave_mode == 1) begin
            if (prev_e && !IO_E) pcnt = 0;
            else if (pcnt >= 0 && pcnt < 20) pcnt++;
            else pcnt = -1;
            pull = (pcnt >= 3 && pcnt <= 12);
        end else if (slave_mode == 2) begin
            if (!prev_e && IO_E) begin
                if (rd_mask[rd_idx]) hold = 10;
                rd_idx = (rd_idx + 1) % 8;
            end
            if (hold > 0) begin
                pull = 1'b1;
                hold--;
            end else begin
                pull = 1'b0;
            end
        end else begin
            pull   = 1'b0;
            pcnt   = -1;
            hold   = 0;
            rd_idx = 0;
        end
        prev_e = IO_E;
    end

    task automatic issue(input logic [1:0] op, input logic [7:0] d);
        CMD_OP    = op;
        CMD_DATA  = d;
        CMD_VALID = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (CMD_READY) begin
                @(posedge CLK); #1;
                CMD_VALID = 1'b0;
                return;
            end
            @(posedge CLK); #1;
        end
        chk("accept_timeout", 0, 1);
        CMD_VALID = 1'b0;
    endtask

    task automatic wait_rsp(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge CLK); #1;
        end
        if (exp_q.size() != 0) begin
            chk("rsp_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ready_hi;
        int found;
        int rises;
        logic pe;

        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        chk("reset_cmd_ready", int'(CMD_READY), 1);
        chk("reset_rsp_valid", int'(RSP_VALID), 0);
        chk("reset_rsp_data", int'(RSP_DATA), 0);
        chk("reset_rsp_presence", int'(RSP_PRESENCE), 0);
        chk("reset_busy", int'(BUSY), 0);
        chk("reset_io_e", int'(IO_E), 0);
        @(posedge CLK); #1;

        // bus reset with a slave answering presence
        slave_mode = 1;
        wid_q.push_back(48);
        push_rsp(8'h00, 1'b1, 98);
        issue(2'b00, 8'h00);
        chk("busy_during_reset", int'(BUSY), 1);
        wait_rsp(200);
        slave_mode = 0;

        // bus reset with no slave
        wid_q.push_back(48);
        push_rsp(8'h00, 1'b0, 98);
        issue(2'b00, 8'h00);
        wait_rsp(200);

        // write 0xA5
        push_widths(2'b01, 8'hA5);
        push_rsp(8'h00, 1'b0, 194);
        issue(2'b01, 8'hA5);
        wait_rsp(400);

        // read, slave drives zeros on bits 1, 4, 7
        slave_mode = 2;
        rd_mask    = 8'h92;
        push_widths(2'b10, 8'h00);
        push_rsp(8'h6D, 1'b0, 194);
        issue(2'b10, 8'h00);
        wait_rsp(400);
        slave_mode = 0;

        // command held valid through a write and across its completion
        push_widths(2'b01, 8'hFF);
        push_rsp(8'h00, 1'b0, 194);
        push_rsp(8'h00, 1'b0, 2);
        CMD_OP = 2'b01; CMD_DATA = 8'hFF; CMD_VALID = 1'b1;
        @(posedge CLK); #1;
        CMD_OP = 2'b11;
        ready_hi = 0;
        found = 0;
        for (int i = 0; i < 300; i++) begin
            if (RSP_VALID) begin
                found = 1;
                break;
            end
            if (CMD_READY) ready_hi++;
            @(posedge CLK); #1;
        end
        chk("held_write_rsp_seen", found, 1);
        chk("ready_high_during_write", ready_hi, 0);
        @(posedge CLK); #1;
        chk("ready_after_rsp", int'(CMD_READY), 1);
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
        chk("second_cmd_accepted", int'(BUSY), 1);
        wait_rsp(50);

        // reset during the low phase of slot 3 of a write of 0x00
        wid_q.push_back(16); wid_q.push_back(16); wid_q.push_back(16);
        issue(2'b01, 8'h00);
        rises = IO_E ? 1 : 0;
        pe = IO_E;
        for (int i = 0; i < 200 && rises < 4; i++) begin
            @(posedge CLK); #1;
            if (IO_E && !pe) rises++;
            pe = IO_E;
        end
        chk("slot3_reached", rises, 4);
        repeat (3) @(posedge CLK);
        #3 RESET = 1'b1;
        #1;
        chk("io_e_async_release", int'(IO_E), 0);
        chk("rsp_valid_in_reset", int'(RSP_VALID), 0);
        chk("busy_in_reset", int'(BUSY), 0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        chk("ready_after_reset", int'(CMD_READY), 1);
        chk("slot3_widths_consumed", wid_q.size(), 0);
        repeat (250) @(posedge CLK);
        #1;

        // read completes normally after the abort
        slave_mode = 2;
        rd_mask    = 8'h0F;
        push_widths(2'b10, 8'h00);
        push_rsp(8'hF0, 1'b0, 194);
        issue(2'b10, 8'h00);
        wait_rsp(400);
        slave_mode = 0;

        // reserved op
        push_rsp(8'h00, 1'b0, 2);
        issue(2'b11, 8'h3C);
        wait_rsp(20);

        repeat (20) @(posedge CLK);
        #1;
        chk("leftover_widths", wid_q.size(), 0);
        chk("leftover_rsp", exp_q.size(), 0);
        chk("final_idle_ready", int'(CMD_READY), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/onewire_master.md
Name: onewire_master

Overview:
- Single-wire (1-Wire style) bus master that drives the D/E/Y side of a bidirectional PF_IO pad instance in open-drain fashion.
- Executes reset/presence, write-byte and read-byte transactions under a valid/ready command interface, with cycle-counted slot timing.
- Sits between a CPU-side register block and the pad wrapper.

Parameters:
- T_RSTL, 24000, reset low time in CLK cycles (480 us at 50 MHz)
- T_RSTH, 24000, released time after reset low, in cycles
- T_PDS, 3500, presence sample point, in cycles after reset release
- T_SLOT, 3500, bit slot length in cycles (70 us)
- T_LOW0, 3000, low time for a write-0 bit
- T_LOW1, 300, low time for a write-1 bit and for a read bit
- T_RDS, 750, read sample point, in cycles from slot start
- T_REC, 500, released recovery time after each slot

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous reset, active-high
- CMD_VALID  in  1  command request
- CMD_READY  out  1  master idle; command is accepted when CMD_VALID & CMD_READY
- CMD_OP  in  2  00=bus reset, 01=write byte, 10=read byte, 11=reserved
- CMD_DATA  in  8  write byte, sent LSB first
- RSP_VALID  out  1  one-cycle completion pulse
- RSP_DATA  out  8  read byte (bit i = slot i); 0 for other ops
- RSP_PRESENCE  out  1  1 = slave presence detected (valid with reset op)
- BUSY  out  1  transaction in progress
- IO_D  out  1  to pad D; constant 0
- IO_E  out  1  to pad E; 1 = pull line low, 0 = release
- IO_Y  in  1  from pad Y; asynchronous line level

Behaviour:
- Reset values: CMD_READY=1 (first cycle after deassert), RSP_VALID=0, RSP_DATA=0, RSP_PRESENCE=0, BUSY=0, IO_E=0, IO_D=0. All counters, FSM and shift register clear.
- RESET mid-transaction: line is released immediately (IO_E=0), no response is issued, FSM goes to IDLE.
- IO_Y passes through a 2-FF synchronizer (Ys). All samples use Ys. Parameter sample points already include the 2-cycle sync latency.
- Counter width is clog2(max timing parameter)+1. Bit index is 3 bits.
- FSM states: IDLE, RST_LOW, RST_HIGH, SLOT, RECOVER, DONE, with the transitions below.
- IDLE: CMD_READY=1, BUSY=0. On accept: latch op and data, clear bit index and counter, CMD_READY=0, BUSY=1 on the next cycle.
  - op 00 -> RST_LOW
  - op 01/10 -> SLOT
  - op 11 -> DONE directly (RSP_DATA=0, RSP_PRESENCE=0)
- RST_LOW: IO_E=1 for exactly T_RSTL cycles, then RST_HIGH.
- RST_HIGH: IO_E=0 for T_RSTH cycles. At count T_PDS, capture presence = ~Ys. At the end, go to DONE.
- SLOT: runs count 0..T_SLOT-1.
  - IO_E=1 while count < low time. Low time is T_LOW1 for a read or a write-1 bit, T_LOW0 for a write-0 bit.
  - Read: at count T_RDS, shift Ys into bit[index].
  - At the end of the slot -> RECOVER.
- RECOVER: IO_E=0 for T_REC cycles. If index==7 -> DONE; else index+1 -> SLOT.
- DONE: RSP_VALID=1 for exactly one cycle, with RSP_DATA/RSP_PRESENCE valid in that cycle. Outputs hold until the next DONE. Next state is IDLE, so CMD_READY returns one cycle after RSP_VALID.
- CMD_VALID while busy is ignored (not queued). A command held through DONE is accepted in the following IDLE cycle.
- IO_E never asserts outside RST_LOW and the low phase of SLOT. IO_E is glitch-free (registered).
- Byte latency after accept: write/read = 1 + 8*(T_SLOT+T_REC) + 1 cycles to RSP_VALID; reset = 1 + T_RSTL + T_RSTH + 1.

Test Plan:
- Override parameters: T_RSTL=48, T_RSTH=48, T_PDS=7, T_SLOT=20, T_LOW0=16, T_LOW1=2, T_RDS=5, T_REC=4.
- Reset with slave model pulling low 3..12 cycles after release -> IO_E high for 48 cycles; RSP_VALID 98 cycles after accept; RSP_PRESENCE=1. Repeat with no slave -> RSP_PRESENCE=0.
- Write 0xA5 -> 8 slots. IO_E low-pulse widths in order are 2,16,2,16,16,2,16,2. RSP_VALID 194 cycles after accept; RSP_DATA=0.
- Read, slave holds line low through sample for bits 1,4,7 -> RSP_DATA=0x6D. Each IO_E pulse is 2 cycles.
- CMD_VALID held high during a write and across DONE -> CMD_READY=0 throughout the write. Second command accepted exactly 1 cycle after RSP_VALID. No extra RSP_VALID pulse.
- Assert RESET during the slot-3 low phase -> IO_E=0 in the same cycle (async). No RSP_VALID. CMD_READY=1 after release. A new read then completes normally.
- op 11 -> RSP_VALID 2 cycles after accept, RSP_DATA=0, IO_E never asserted.
